// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with clock enable, sync polarity control and
// a latency-matched hs/vs/de/rgb output pipeline for pixel logic of LAT ce-cycles.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int CDW      = 4,
  parameter int LAT      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  output logic [CW-1:0]    px_x,
  output logic [CW-1:0]    px_y,
  output logic             de_early,
  output logic             line_start,
  output logic             frame_start,
  input  logic [3*CDW-1:0] rgb_in,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [3*CDW-1:0] rgb_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Compares use CW+1 bits so a sync window ending exactly at 2^CW does not wrap to zero.
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW:0]   H_ACT_C = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0]   H_SB_C  = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0]   H_SE_C  = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0]   V_ACT_C = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0]   V_SB_C  = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0]   V_SE_C  = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  // cnt_x/cnt_y hold the coordinate that the next ce will publish on px_x/px_y.
  logic [CW-1:0] cnt_x, cnt_y;
  logic [CW:0]   cx, cy;
  logic          hs_dec, vs_dec, de_dec;
  logic [LAT:0]  hs_pipe, vs_pipe, de_pipe;
  logic [LAT:0]  hs_feed, vs_feed, de_feed;

  assign cx = {1'b0, cnt_x};
  assign cy = {1'b0, cnt_y};

  always_comb begin
    hs_dec = ~HS_POL;
    vs_dec = ~VS_POL;
    if ((cx >= H_SB_C) && (cx < H_SE_C)) hs_dec = HS_POL;
    if ((cy >= V_SB_C) && (cy < V_SE_C)) vs_dec = VS_POL;
    de_dec = (cx < H_ACT_C) && (cy < V_ACT_C);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else if (ce) begin
      if (cnt_x == H_LAST) begin
        cnt_x <= '0;
        cnt_y <= (cnt_y == V_LAST) ? '0 : cnt_y + 1'b1;
      end else begin
        cnt_x <= cnt_x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      px_x        <= '0;
      px_y        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      px_x        <= cnt_x;
      px_y        <= cnt_y;
      line_start  <= (cnt_x == '0);
      frame_start <= (cnt_x == '0) && (cnt_y == '0);
    end
  end

  // Stage 0 is aligned with px_x/px_y; stage LAT drives the outputs.
  generate
    if (LAT == 0) begin : g_feed0
      assign hs_feed = hs_dec;
      assign vs_feed = vs_dec;
      assign de_feed = de_dec;
    end else begin : g_feedn
      assign hs_feed = {hs_pipe[LAT-1:0], hs_dec};
      assign vs_feed = {vs_pipe[LAT-1:0], vs_dec};
      assign de_feed = {de_pipe[LAT-1:0], de_dec};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_pipe <= {(LAT+1){~HS_POL}};
      vs_pipe <= {(LAT+1){~VS_POL}};
      de_pipe <= '0;
      rgb_out <= '0;
    end else if (ce) begin
      hs_pipe <= hs_feed;
      vs_pipe <= vs_feed;
      de_pipe <= de_feed;
      rgb_out <= {(3*CDW){de_feed[LAT]}} & rgb_in;
    end
  end

  assign de_early = de_pipe[0];
  assign hs       = hs_pipe[LAT];
  assign vs       = vs_pipe[LAT];
  assign de       = de_pipe[LAT];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: stimulus pushes expected raster state per clock, a monitor pops and compares.
// Three instances share clk/reset/ce: default timing, tiny LAT=0 raster, tiny inverted-polarity LAT=1.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset, ce;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        dee;
    logic        ls;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] rgb;
  } obs_t;

  localparam logic [11:0] RGB_D = 12'hF00;
  localparam logic [11:0] RGB_S = 12'h5A3;
  localparam logic [11:0] RGB_P = 12'h0FF;

  logic [9:0]  x_d, y_d;
  logic [3:0]  x_s, y_s, x_p, y_p;
  logic        dee_d, ls_d, fs_d, hs_d, vs_d, de_d;
  logic        dee_s, ls_s, fs_s, hs_s, vs_s, de_s;
  logic        dee_p, ls_p, fs_p, hs_p, vs_p, de_p;
  logic [11:0] rgb_d, rgb_s, rgb_p;
  logic [11:0] rgbi_d, rgbi_s, rgbi_p;

  vga_timing_gen u_def (
    .clk(clk), .reset(reset), .ce(ce), .px_x(x_d), .px_y(y_d), .de_early(dee_d),
    .line_start(ls_d), .frame_start(fs_d), .rgb_in(rgbi_d), .hs(hs_d), .vs(vs_d),
    .de(de_d), .rgb_out(rgb_d));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .CW(4), .LAT(0)) u_small (
    .clk(clk), .reset(reset), .ce(ce), .px_x(x_s), .px_y(y_s), .de_early(dee_s),
    .line_start(ls_s), .frame_start(fs_s), .rgb_in(rgbi_s), .hs(hs_s), .vs(vs_s),
    .de(de_s), .rgb_out(rgb_s));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .LAT(1)) u_pol (
    .clk(clk), .reset(reset), .ce(ce), .px_x(x_p), .px_y(y_p), .de_early(dee_p),
    .line_start(ls_p), .frame_start(fs_p), .rgb_in(rgbi_p), .hs(hs_p), .vs(vs_p),
    .de(de_p), .rgb_out(rgb_p));

  obs_t q_def[$], q_sm[$], q_pol[$];
  int checks = 0;
  int errors = 0;
  int n = 0;

  // Expected outputs after n ce steps since reset, straight from the raster layout.
  function automatic obs_t model(int steps, int ha, int hf, int hsw, int hb, int va, int vf,
                                 int vsw, int vb, int lat, bit hp, bit vp, logic [11:0] rgb);
    obs_t o;
    int ht, vt, k, j, xj, yj;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    o = '0;
    o.hs = ~hp;
    o.vs = ~vp;
    if (steps == 0) return o;
    k = steps - 1;
    o.x = 10'(k % ht);
    o.y = 10'((k / ht) % vt);
    o.dee = (int'(o.x) < ha) && (int'(o.y) < va);
    o.ls = (o.x == 10'd0);
    o.fs = (o.x == 10'd0) && (o.y == 10'd0);
    j = k - lat;
    if (j >= 0) begin
      xj = j % ht;
      yj = (j / ht) % vt;
      o.hs = (xj >= ha + hf && xj < ha + hf + hsw) ? hp : ~hp;
      o.vs = (yj >= va + vf && yj < va + vf + vsw) ? vp : ~vp;
      o.de = (xj < ha) && (yj < va);
      o.rgb = o.de ? rgb : 12'h000;
    end
    return o;
  endfunction

  function automatic obs_t exp_def(int s);
    return model(s, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0, RGB_D);
  endfunction
  function automatic obs_t exp_sm(int s);
    return model(s, 4, 1, 2, 1, 3, 1, 1, 1, 0, 1'b0, 1'b0, RGB_S);
  endfunction
  function automatic obs_t exp_pol(int s);
    return model(s, 4, 1, 2, 1, 3, 1, 1, 1, 1, 1'b1, 1'b1, RGB_P);
  endfunction

  function automatic obs_t act_def();
    return {x_d, y_d, dee_d, ls_d, fs_d, hs_d, vs_d, de_d, rgb_d};
  endfunction
  function automatic obs_t act_sm();
    return {6'd0, x_s, 6'd0, y_s, dee_s, ls_s, fs_s, hs_s, vs_s, de_s, rgb_s};
  endfunction
  function automatic obs_t act_pol();
    return {6'd0, x_p, 6'd0, y_p, dee_p, ls_p, fs_p, hs_p, vs_p, de_p, rgb_p};
  endfunction

  task automatic cmp(string name, obs_t a, obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, a, e);
    end
  endtask

  task automatic checkv(string name, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, a, e);
    end
  endtask

  task automatic check_reset_all(string tag);
    cmp({tag, "_def"}, act_def(), exp_def(0));
    cmp({tag, "_sm"},  act_sm(),  exp_sm(0));
    cmp({tag, "_pol"}, act_pol(), exp_pol(0));
  endtask

  // Called 2 time units after a posedge; ends 2 units after the next posedge.
  task automatic step(bit c);
    ce = c;
    if (c) n++;
    q_def.push_back(exp_def(n));
    q_sm.push_back(exp_sm(n));
    q_pol.push_back(exp_pol(n));
    @(posedge clk);
    #2;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_def.size() > 0) cmp("mon_def", act_def(), q_def.pop_front());
      if (q_sm.size() > 0)  cmp("mon_sm",  act_sm(),  q_sm.pop_front());
      if (q_pol.size() > 0) cmp("mon_pol", act_pol(), q_pol.pop_front());
    end
  end

  int ls_cnt, fs_cnt, hs_lo_cnt, de_cnt, rgb_cnt, pol_hs_cnt;

  initial begin
    reset  = 1'b0;
    ce     = 1'b0;
    rgbi_d = RGB_D;
    rgbi_s = RGB_S;
    rgbi_p = RGB_P;
    repeat (3) @(posedge clk);
    #2;
    check_reset_all("reset");
    reset = 1'b1;
    n = 0;

    // Free run: full first line of the default raster, many tiny frames.
    ls_cnt = 0; fs_cnt = 0; hs_lo_cnt = 0; de_cnt = 0; rgb_cnt = 0; pol_hs_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1);
      ls_cnt     += int'(ls_s);
      fs_cnt     += int'(fs_s);
      hs_lo_cnt  += int'(!hs_d);
      de_cnt     += int'(de_d);
      rgb_cnt    += int'(rgb_d == RGB_D);
      pol_hs_cnt += int'(hs_p);
    end
    checkv("small_line_starts", ls_cnt, 125);
    checkv("small_frame_starts", fs_cnt, 21);
    checkv("def_hs_low_cycles", hs_lo_cnt, 96);
    checkv("def_de_cycles", de_cnt, 838);
    checkv("def_rgb_on_cycles", rgb_cnt, 838);
    checkv("pol_hs_high_cycles", pol_hs_cnt, 250);

    // Half-rate ce.
    for (int i = 0; i < 400; i++) step(1'(i % 2 == 0));

    // ce held low for several clocks, landing on various points including wraps.
    for (int r = 0; r < 20; r++) begin
      repeat (5) step(1'b1);
      repeat (4) step(1'b0);
    end

    // Asynchronous reset between edges, mid-frame.
    #1;
    reset = 1'b0;
    #1;
    check_reset_all("async_reset");
    n = 0;
    ce = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_reset_all("held_reset");
    reset = 1'b1;
    for (int i = 0; i < 60; i++) step(1'b1);
    step(1'b0);

    @(posedge clk);
    #3;
    checkv("queues_drained", q_def.size() + q_sm.size() + q_pol.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
